bus_source_encoder: RTL and testbench

//  - Registered encoder that turns one-hot bus-drive strobes into the 5-bit select for the datapath bus mux.
//  - The 16 register strobes come from the select/encode stage (registersOut). The 8 special-source strobes come from the control unit.
//  - Detects multiple drivers on the same cycle, resolves them by fixed priority and flags the contention for debug and verification.

---
 rtl/cpu_bus_pkg.sv | 51 +++++
 rtl/prio_encoder24.sv | 38 +++
 rtl/bus_source_encoder.sv | 82 ++++++++
 tb/tb_bus_source_encoder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the datapath bus source selection logic.
// Holds the bus mux select codes, the request vector geometry and the
// encoder FSM state encodings. Both the encoder and the bus mux use it.
package cpu_bus_pkg;

  localparam int NUM_REGS    = 16;
  localparam int NUM_SPECIAL = 8;
  localparam int REQ_W       = NUM_REGS + NUM_SPECIAL;
  localparam int SEL_W       = 5;
  localparam int CNT_W       = 8;

  // Register sources occupy codes 0..15. Code k is register Rk.
  localparam logic [SEL_W-1:0] SEL_R0  = 5'd0;
  localparam logic [SEL_W-1:0] SEL_R1  = 5'd1;
  localparam logic [SEL_W-1:0] SEL_R2  = 5'd2;
  localparam logic [SEL_W-1:0] SEL_R3  = 5'd3;
  localparam logic [SEL_W-1:0] SEL_R4  = 5'd4;
  localparam logic [SEL_W-1:0] SEL_R5  = 5'd5;
  localparam logic [SEL_W-1:0] SEL_R6  = 5'd6;
  localparam logic [SEL_W-1:0] SEL_R7  = 5'd7;
  localparam logic [SEL_W-1:0] SEL_R8  = 5'd8;
  localparam logic [SEL_W-1:0] SEL_R9  = 5'd9;
  localparam logic [SEL_W-1:0] SEL_R10 = 5'd10;
  localparam logic [SEL_W-1:0] SEL_R11 = 5'd11;
  localparam logic [SEL_W-1:0] SEL_R12 = 5'd12;
  localparam logic [SEL_W-1:0] SEL_R13 = 5'd13;
  localparam logic [SEL_W-1:0] SEL_R14 = 5'd14;
  localparam logic [SEL_W-1:0] SEL_R15 = 5'd15;

  // Special sources occupy codes 16..23, in specOut bit order.
  localparam logic [SEL_W-1:0] SEL_HI     = 5'd16;
  localparam logic [SEL_W-1:0] SEL_LO     = 5'd17;
  localparam logic [SEL_W-1:0] SEL_ZHI    = 5'd18;
  localparam logic [SEL_W-1:0] SEL_ZLO    = 5'd19;
  localparam logic [SEL_W-1:0] SEL_PC     = 5'd20;
  localparam logic [SEL_W-1:0] SEL_MDR    = 5'd21;
  localparam logic [SEL_W-1:0] SEL_INPORT = 5'd22;
  localparam logic [SEL_W-1:0] SEL_C      = 5'd23;

  // No source: the bus mux drives zero.
  localparam logic [SEL_W-1:0] SEL_NONE = 5'd31;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_FAULT = 2'd2
  } enc_state_t;

endpackage

// File: rtl/prio_encoder24.sv
// Combinational 24-input priority encoder.
// Ports:
//   req   in  24  request strobes, bit k maps to select code k
//   any   out 1   at least one strobe set
//   multi out 1   two or more strobes set
//   idx   out 5   lowest set index (0 when none set)
// Unknown request bits are treated as set in simulation so that an X on a
// strobe shows up as a driver instead of silently vanishing.
module prio_encoder24
  import cpu_bus_pkg::*;
(
  input  logic [REQ_W-1:0] req,
  output logic             any,
  output logic             multi,
  output logic [SEL_W-1:0] idx
);

  logic [REQ_W-1:0] req_k;

  always_comb begin
    for (int k = 0; k < REQ_W; k++) begin
      req_k[k] = (req[k] !== 1'b0);
    end
  end

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int k = REQ_W - 1; k >= 0; k--) begin
      if (req_k[k]) idx = SEL_W'(k);
    end
  end

  assign any = |req_k;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req_k & (req_k - REQ_W'(1)));

endmodule

// File: rtl/bus_source_encoder.sv
// Registered bus source encoder.
// Turns the one-hot register and special drive strobes into the bus mux
// select, one cycle after they are sampled. Multiple drivers on one cycle
// are resolved by lowest index and recorded in a sticky flag and a
// saturating counter.
// Ports:
//   clk            in  1      rising-edge clock
//   clr            in  1      synchronous reset, active-low
//   regOut         in  16     register drive strobes, bit i = Ri out
//   specOut        in  8      special strobes, bit0 HI .. bit7 C
//   clearConflict  in  1      clears conflict flag and counter
//   busSel         out 5      registered bus mux select
//   busValid       out 1      busSel names a real source
//   conflict       out 1      sticky multi-driver flag
//   conflictCount  out 8      conflicting cycles, saturating
//   state          out 2      FSM state (0 IDLE, 1 DRIVE, 2 FAULT)
module bus_source_encoder
  import cpu_bus_pkg::*;
(
  input  logic                   clk,
  input  logic                   clr,
  input  logic [NUM_REGS-1:0]    regOut,
  input  logic [NUM_SPECIAL-1:0] specOut,
  input  logic                   clearConflict,
  output logic [SEL_W-1:0]       busSel,
  output logic                   busValid,
  output logic                   conflict,
  output logic [CNT_W-1:0]       conflictCount,
  output logic [1:0]             state
);

  logic             any;
  logic             multi;
  logic [SEL_W-1:0] idx;
  enc_state_t       state_q;

  prio_encoder24 u_prio (
    .req   ({specOut, regOut}),
    .any   (any),
    .multi (multi),
    .idx   (idx)
  );

  // Every state is reachable from every state in one edge; the next state
  // depends only on how many strobes are set this cycle.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q       <= ST_IDLE;
      busSel        <= SEL_NONE;
      busValid      <= 1'b0;
      conflict      <= 1'b0;
      conflictCount <= '0;
    end else begin
      if (!any) begin
        state_q  <= ST_IDLE;
        busSel   <= SEL_NONE;
        busValid <= 1'b0;
      end else begin
        state_q  <= multi ? ST_FAULT : ST_DRIVE;
        busSel   <= idx;
        busValid <= 1'b1;
      end

      // A conflict on the same edge as a clear wins: the clear wipes the
      // history and this cycle becomes the first recorded conflict.
      if (multi) begin
        conflict <= 1'b1;
        if (clearConflict) begin
          conflictCount <= CNT_W'(1);
        end else if (conflictCount != CNT_MAX) begin
          conflictCount <= conflictCount + CNT_W'(1);
        end
      end else if (clearConflict) begin
        conflict      <= 1'b0;
        conflictCount <= '0;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_bus_source_encoder.sv
// Bench for bus_source_encoder: directed steps from the block's test plan
// followed by randomized traffic, all checked against a request-level model.
module tb_bus_source_encoder;

  logic        clk;
  logic        clr;
  logic [15:0] regOut;
  logic [7:0]  specOut;
  logic        clearConflict;
  logic [4:0]  busSel;
  logic        busValid;
  logic        conflict;
  logic [7:0]  conflictCount;
  logic [1:0]  state;

  int n_assert;
  int n_fail;

  // Reference model state
  int m_sel;
  int m_valid;
  int m_state;
  int m_conflict;
  int m_count;

  bus_source_encoder dut (
    .clk           (clk),
    .clr           (clr),
    .regOut        (regOut),
    .specOut       (specOut),
    .clearConflict (clearConflict),
    .busSel        (busSel),
    .busValid      (busValid),
    .conflict      (conflict),
    .conflictCount (conflictCount),
    .state         (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model of one clock edge, from the rules: lowest set request index wins,
  // number of set strobes picks IDLE/DRIVE/FAULT, conflicts are counted up
  // to 255, and a clear loses to a conflict on the same edge.
  task automatic model_edge(input logic [15:0] r, input logic [7:0] s,
                            input logic c, input logic cc);
    logic [23:0] req;
    int n;
    int low;
    req = {s, r};
    n = $countones(req);
    low = -1;
    for (int k = 0; k < 24; k++) begin
      if (req[k] && low < 0) low = k;
    end
    if (!c) begin
      m_sel = 31; m_valid = 0; m_state = 0; m_conflict = 0; m_count = 0;
    end else begin
      if (n == 0) begin
        m_sel = 31; m_valid = 0; m_state = 0;
      end else begin
        m_sel = low; m_valid = 1; m_state = (n >= 2) ? 2 : 1;
      end
      if (n >= 2) begin
        m_conflict = 1;
        m_count = cc ? 1 : ((m_count < 255) ? m_count + 1 : 255);
      end else if (cc) begin
        m_conflict = 0;
        m_count = 0;
      end
    end
  endtask

  // Driver: apply inputs, take one edge, update the model, check at negedge.
  task automatic step(input logic [15:0] r, input logic [7:0] s,
                      input logic c, input logic cc, input string tag);
    regOut = r;
    specOut = s;
    clr = c;
    clearConflict = cc;
    @(posedge clk);
    model_edge(r, s, c, cc);
    @(negedge clk);
    check({tag, ".busSel"}, int'(busSel), m_sel);
    check({tag, ".busValid"}, int'(busValid), m_valid);
    check({tag, ".state"}, int'(state), m_state);
    check({tag, ".conflict"}, int'(conflict), m_conflict);
    check({tag, ".count"}, int'(conflictCount), m_count);
  endtask

  initial begin
    logic [23:0] rq;
    logic        rc;
    logic        rcc;
    int          mode;
    n_assert = 0;
    n_fail = 0;
    m_sel = 31; m_valid = 0; m_state = 0; m_conflict = 0; m_count = 0;
    regOut = '0; specOut = '0; clr = 1'b0; clearConflict = 1'b0;

    // Reset with every register strobe active
    step(16'hFFFF, 8'h00, 1'b0, 1'b0, "reset0");
    step(16'hFFFF, 8'h00, 1'b0, 1'b0, "reset1");
    check("reset.sel_const", int'(busSel), 31);

    // Single drivers
    step(16'h0020, 8'h00, 1'b1, 1'b0, "single_r5");
    check("single_r5.sel_const", int'(busSel), 5);
    step(16'h0000, 8'h10, 1'b1, 1'b0, "single_pc");
    check("single_pc.sel_const", int'(busSel), 20);
    step(16'h0000, 8'h80, 1'b1, 1'b0, "single_c");
    step(16'h8000, 8'h00, 1'b1, 1'b0, "single_r15");

    // Conflict, then idle
    step(16'h0108, 8'h01, 1'b1, 1'b0, "conflict");
    check("conflict.sel_const", int'(busSel), 3);
    check("conflict.count_const", int'(conflictCount), 1);
    step(16'h0000, 8'h00, 1'b1, 1'b0, "idle_after");
    check("idle_after.sticky", int'(conflict), 1);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      step(16'h0000, 8'h81, 1'b1, 1'b0, "sat");
    end
    check("sat.count_const", int'(conflictCount), 255);
    step(16'h0000, 8'h00, 1'b1, 1'b1, "clear");
    check("clear.count_const", int'(conflictCount), 0);

    // Clear and conflict on the same edge
    step(16'h0003, 8'h00, 1'b1, 1'b1, "clear_and_conflict");
    check("clear_and_conflict.count_const", int'(conflictCount), 1);
    check("clear_and_conflict.sel_const", int'(busSel), 0);

    // Reset mid-FAULT with count 7, then one-cycle recovery
    step(16'h0000, 8'h00, 1'b1, 1'b1, "pre_fault_clear");
    for (int i = 0; i < 7; i++) begin
      step(16'h1000, 8'h40, 1'b1, 1'b0, "build7");
    end
    check("build7.count_const", int'(conflictCount), 7);
    step(16'h1000, 8'h40, 1'b0, 1'b0, "reset_mid_fault");
    step(16'h0400, 8'h00, 1'b1, 1'b0, "recover");
    check("recover.sel_const", int'(busSel), 10);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 3);
      rq = '0;
      case (mode)
        0: rq = '0;
        1: rq[$urandom_range(0, 23)] = 1'b1;
        2: begin
          rq[$urandom_range(0, 23)] = 1'b1;
          rq[$urandom_range(0, 23)] = 1'b1;
        end
        default: rq = 24'($urandom);
      endcase
      rc = ($urandom_range(0, 49) != 0);
      rcc = ($urandom_range(0, 7) == 0);
      step(rq[15:0], rq[23:16], rc, rcc, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
